// File: rtl/load_data_align_unit_pkg.sv
// Shared types and constants for the load-data align unit.
package load_align_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

endpackage

// File: rtl/load_data_extract.sv
// Combinational byte extraction: shifts the {HI,LO} pair down to the
// addressed offset, keeps 2^size bytes and sign/zero-extends to DATA_SIZE.
module load_data_extract
  import load_align_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic [2*DATA_SIZE-1:0]          i_dw,
  input  logic [$clog2(DATA_SIZE/8)-1:0]  i_off,
  input  logic [1:0]                      i_size,
  input  logic                            i_unsigned,
  output logic [DATA_SIZE-1:0]            o_data
);

  logic [2*DATA_SIZE-1:0] w_shift;
  int                     w_nbits;
  logic                   w_sign;

  // Shift, pick the sign bit at nbits-1, then fill everything above nbits.
  // A full-width access has no bits above nbits, so it is left untouched.
  always_comb begin
    w_shift = i_dw >> {i_off, 3'b000};
    w_nbits = 8 << i_size;
    w_sign  = 1'b0;
    for (int i = 0; i < 2*DATA_SIZE; i++) begin
      if (i == w_nbits - 1) w_sign = w_shift[i] & ~i_unsigned;
    end
    o_data = w_shift[DATA_SIZE-1:0];
    for (int i = 0; i < DATA_SIZE; i++) begin
      if (i >= w_nbits) o_data[i] = w_sign;
    end
  end

endmodule

// File: rtl/load_data_align_unit.sv
// Load-data align unit: accepts one load at a time, issues one or two
// aligned word reads, and returns the extracted, extended result.
//
//   state | meaning
//   IDLE  | ready for a request
//   RD0   | reading the word holding the first byte (LO)
//   RD1   | reading the next word for a boundary-crossing access (HI)
//   RESP  | result held until the consumer takes it
module load_data_align_unit
  import load_align_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  mem_req,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  input  logic                  mem_rvalid,
  input  logic [DATA_SIZE-1:0]  mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_SIZE-1:0]  rsp_data,
  output logic                  rsp_misaligned,
  output logic                  rsp_err
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int OFFW  = $clog2(BYTES);

  state_t                 r_state, w_next;
  logic [OFFW-1:0]        r_off;
  logic [1:0]             r_size;
  logic                   r_unsigned;
  logic [DATA_SIZE-1:0]   r_lo, r_hi;
  logic                   r_mem_req;
  logic [ADDR_SIZE-1:0]   r_mem_addr;
  logic                   r_rsp_valid;
  logic [DATA_SIZE-1:0]   r_rsp_data;
  logic                   r_rsp_mis;
  logic                   r_rsp_err;

  logic                   w_illegal;
  logic                   w_cross;
  logic [ADDR_SIZE-1:0]   w_base;
  logic [DATA_SIZE-1:0]   w_lo, w_hi, w_ext;

  assign w_illegal = req_size > 2'(OFFW);
  assign w_cross   = (32'(r_off) + (32'd1 << r_size)) > 32'(BYTES);
  assign w_base    = req_addr & ~ADDR_SIZE'(BYTES - 1);

  // The word arriving this cycle feeds extraction directly so the result
  // can be registered on the same edge that completes the read.
  assign w_lo = (r_state == RD0) ? mem_rdata : r_lo;
  assign w_hi = (r_state == RD1) ? mem_rdata : r_hi;

  load_data_extract #(.DATA_SIZE(DATA_SIZE)) u_extract (
    .i_dw       ({w_hi, w_lo}),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (req_valid) w_next = w_illegal ? RESP : RD0;
      RD0:  if (mem_rvalid) w_next = w_cross ? RD1 : RESP;
      RD1:  if (mem_rvalid) w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, read data storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off       <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_mis   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_off      <= req_addr[OFFW-1:0];
          r_size     <= req_size;
          r_unsigned <= req_unsigned;
          r_lo       <= '0;
          r_hi       <= '0;
          if (w_illegal) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_mis   <= 1'b0;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_base;
          end
        end
        RD0: if (mem_rvalid) begin
          r_lo <= mem_rdata;
          if (w_cross) begin
            r_mem_addr <= r_mem_addr + ADDR_SIZE'(BYTES);
          end else begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_ext;
            r_rsp_mis   <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
        RD1: if (mem_rvalid) begin
          r_hi        <= mem_rdata;
          r_mem_req   <= 1'b0;
          r_mem_addr  <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_ext;
          r_rsp_mis   <= 1'b1;
          r_rsp_err   <= 1'b0;
        end
        RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_rsp_data  <= '0;
          r_rsp_mis   <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = (r_state == IDLE);
  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_misaligned = r_rsp_mis;
  assign rsp_err        = r_rsp_err;

endmodule

// File: tb/tb_load_data_align_unit.sv
// Directed bench for load_data_align_unit at DATA_SIZE=32.
module tb_load_data_align_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_misaligned;
  logic        rsp_err;

  int vectors = 0;
  int misses  = 0;

  logic [31:0] m_addr0, m_data0, m_addr1, m_data1;

  load_data_align_unit #(.DATA_SIZE(32), .ADDR_SIZE(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_misaligned (rsp_misaligned),
    .rsp_err        (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lookup(input logic [31:0] a);
    if (a == m_addr0) return m_data0;
    if (a == m_addr1) return m_data1;
    return 32'hDEAD_BEEF;
  endfunction

  // Issues one load from a negedge, plays memory with a fixed wait count,
  // checks result, latency and read addresses, then applies backpressure.
  task automatic run_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input int waits, input int hold,
                          input logic [31:0] exp_data, input logic exp_mis, input logic exp_err,
                          input int exp_lat, input int exp_nrd,
                          input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    int          wcnt  = 0;
    bit          in_rd = 0;
    bit          done  = 0;
    logic [31:0] first = 0;
    logic [31:0] a0 = 0, a1 = 0;
    int          nrd = 0;
    int          lat = 0;
    check({name, "_req_ready_idle"}, req_ready, 1);
    req_addr = addr; req_size = size; req_unsigned = uns; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      if (rsp_valid) begin
        done = 1;
        lat  = cyc;
      end else begin
        if (mem_req) begin
          if (!in_rd) begin
            in_rd = 1;
            first = mem_addr;
            if (nrd == 0) a0 = mem_addr; else a1 = mem_addr;
            nrd++;
          end else begin
            check({name, "_mem_addr_stable"}, mem_addr, first);
          end
          if (wcnt == waits) begin
            mem_rvalid = 1'b1;
            mem_rdata  = lookup(first);
            in_rd      = 0;
            wcnt       = 0;
          end else begin
            mem_rvalid = 1'b0;
            wcnt++;
          end
        end else begin
          mem_rvalid = 1'b0;
        end
        @(negedge clk);
      end
    end
    mem_rvalid = 1'b0;
    if (!done) check({name, "_rsp_timeout"}, 0, 1);
    check({name, "_lat"},  lat, exp_lat);
    check({name, "_nrd"},  nrd, exp_nrd);
    if (exp_nrd > 0) check({name, "_addr0"}, a0, exp_a0);
    if (exp_nrd > 1) check({name, "_addr1"}, a1, exp_a1);
    check({name, "_data"}, rsp_data, exp_data);
    check({name, "_mis"},  rsp_misaligned, exp_mis);
    check({name, "_err"},  rsp_err, exp_err);
    check({name, "_mem_req_off"}, mem_req, 0);
    check({name, "_req_ready_busy"}, req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, rsp_valid, 1);
      check({name, "_hold_data"},  rsp_data, exp_data);
      check({name, "_hold_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_rsp_done"}, rsp_valid, 0);
    check({name, "_ready_back"}, req_ready, 1);
  endtask

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_unsigned = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    m_addr0 = '0; m_data0 = '0; m_addr1 = '0; m_data1 = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_req",   mem_req, 0);
    check("rst_mem_addr",  mem_addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data",  rsp_data, 0);
    check("rst_rsp_mis",   rsp_misaligned, 0);
    check("rst_rsp_err",   rsp_err, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    m_addr0 = 32'h0000_1000; m_data0 = 32'h80FF_1234;
    run_load("lb",   32'h0000_1003, 2'd0, 1'b0, 0, 0, 32'hFFFF_FF80, 0, 0, 2, 1, 32'h0000_1000, 0);
    run_load("lbu",  32'h0000_1003, 2'd0, 1'b1, 0, 0, 32'h0000_0080, 0, 0, 2, 1, 32'h0000_1000, 0);
    run_load("lb1",  32'h0000_1001, 2'd0, 1'b0, 0, 0, 32'h0000_0012, 0, 0, 2, 1, 32'h0000_1000, 0);

    m_data0 = 32'h8001_5678;
    run_load("lh",   32'h0000_1002, 2'd1, 1'b0, 0, 0, 32'hFFFF_8001, 0, 0, 2, 1, 32'h0000_1000, 0);
    run_load("lhu",  32'h0000_1002, 2'd1, 1'b1, 0, 0, 32'h0000_8001, 0, 0, 2, 1, 32'h0000_1000, 0);

    m_data0 = 32'h4433_2211; m_addr1 = 32'h0000_1004; m_data1 = 32'h8877_6655;
    run_load("lw_mis", 32'h0000_1001, 2'd2, 1'b0, 0, 0, 32'h5544_3322, 1, 0, 3, 2, 32'h0000_1000, 32'h0000_1004);

    m_addr0 = 32'hFFFF_FFFC; m_data0 = 32'h7F00_0000; m_addr1 = 32'h0000_0000; m_data1 = 32'h0000_00C3;
    run_load("lh_wrap",  32'hFFFF_FFFF, 2'd1, 1'b0, 0, 0, 32'hFFFF_C37F, 1, 0, 3, 2, 32'hFFFF_FFFC, 32'h0000_0000);
    run_load("lh_wrapw", 32'hFFFF_FFFF, 2'd1, 1'b0, 2, 0, 32'hFFFF_C37F, 1, 0, 7, 2, 32'hFFFF_FFFC, 32'h0000_0000);

    m_addr0 = 32'h0000_2000; m_data0 = 32'h1234_5678;
    run_load("lw_bp",  32'h0000_2000, 2'd2, 1'b0, 0, 3, 32'h1234_5678, 0, 0, 2, 1, 32'h0000_2000, 0);

    run_load("illegal", 32'h0000_3000, 2'd3, 1'b0, 0, 0, 32'h0000_0000, 0, 1, 1, 0, 0, 0);

    // Reset while the second read of a misaligned word is outstanding.
    m_addr0 = 32'h0000_1000; m_data0 = 32'h4433_2211; m_addr1 = 32'h0000_1004; m_data1 = 32'h8877_6655;
    req_addr = 32'h0000_1001; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst1_rd0_addr", mem_addr, 32'h0000_1000);
    mem_rvalid = 1'b1; mem_rdata = m_data0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst1_rd1_req",  mem_req, 1);
    check("rst1_rd1_addr", mem_addr, 32'h0000_1004);
    #2 rst_n = 1'b0;
    #1;
    check("rst1_mem_req",   mem_req, 0);
    check("rst1_mem_addr",  mem_addr, 0);
    check("rst1_rsp_valid", rsp_valid, 0);
    check("rst1_rsp_data",  rsp_data, 0);
    check("rst1_rsp_mis",   rsp_misaligned, 0);
    check("rst1_rsp_err",   rsp_err, 0);
    check("rst1_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = m_data1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst1_late_rsp_valid", rsp_valid, 0);
      check("rst1_late_mem_req",   mem_req, 0);
      check("rst1_late_req_ready", req_ready, 1);
    end
    mem_rvalid = 1'b0;

    m_data0 = 32'h80FF_1234;
    run_load("post_rst", 32'h0000_1003, 2'd0, 1'b1, 0, 0, 32'h0000_0080, 0, 0, 2, 1, 32'h0000_1000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/load_data_align_unit.md
# load_data_align_unit

Sequential load-data unit between the CPU memory stage and the data memory port. It accepts a load request (byte address, size, signedness) and issues one or two aligned word reads, two when the access crosses a word boundary. It then extracts the addressed bytes, sign- or zero-extends them, and returns the result over a valid/ready handshake. It generalises byte-only, single-word extraction to byte/half/word (and double when DATA_SIZE=64) accesses, with misaligned support and memory wait states.

## Interface
- DATA_SIZE, 32, memory word and result width; 32 or 64.
- ADDR_SIZE, 32, byte-address width.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  load request present.
- req_ready  output  1  unit can accept a request.
- req_addr  input  ADDR_SIZE  byte address.
- req_size  input  2  log2 of access bytes: 0 byte, 1 half, 2 word, 3 double.
- req_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
- mem_req  output  1  read request to memory.
- mem_addr  output  ADDR_SIZE  word-aligned read address.
- mem_rvalid  input  1  mem_rdata valid for the outstanding read.
- mem_rdata  input  DATA_SIZE  read word.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  DATA_SIZE  extended load result.
- rsp_misaligned  output  1  result needed two reads.
- rsp_err  output  1  illegal size; rsp_data is 0.

## Operation
- BYTES = DATA_SIZE/8. OFF = req_addr mod BYTES. NB = 1<<req_size.
- States: IDLE, RD0, RD1, RESP.
- IDLE: req_ready=1. On req_valid, capture addr, size and unsigned flag.
  - If req_size > log2(BYTES): go to RESP with rsp_err=1, rsp_data=0, and no mem_req.
  - Otherwise go to RD0.
- RD0: mem_req=1, mem_addr = addr with the low log2(BYTES) bits cleared. Both are held until mem_rvalid. On mem_rvalid, store the word as LO.
  - If OFF+NB > BYTES, go to RD1.
  - Otherwise go to RESP.
- RD1: mem_req=1, mem_addr = RD0 address + BYTES, wrapping mod 2^ADDR_SIZE. On mem_rvalid, store the word as HI and go to RESP.
- Extraction: build {HI,LO} (HI=0 if unused), shift right by OFF*8, keep the low NB*8 bits, then extend to DATA_SIZE. Sign comes from bit NB*8-1, unless req_unsigned. A full-width access is not extended.
- RESP: rsp_valid=1. rsp_data, rsp_misaligned and rsp_err stay stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE.
- req_ready is 0 outside IDLE. Only one request is in flight.
- mem_rvalid outside RD0/RD1 is ignored.

## Timing
- Reset (async assert, sync release): state IDLE, req_ready=1; mem_req, mem_addr, rsp_valid, rsp_data, rsp_misaligned, rsp_err all 0. Stored LO/HI are cleared.
- Reset mid-operation abandons the access. No mem_req or rsp_valid is issued for it after reset releases.
- All outputs are registered except req_ready, which decodes state==IDLE from a register.
- Latency with zero-wait memory (mem_rvalid in the first mem_req cycle):
  - Aligned: request accepted at edge 0, mem_req during cycle 1, rsp_valid from cycle 2.
  - Misaligned: rsp_valid from cycle 3.
  - Illegal size: rsp_valid from cycle 1.
- Each memory wait cycle adds one cycle; mem_addr stays constant while waiting.
- Minimum request-to-request spacing is 3 cycles aligned, 4 misaligned (RESP→IDLE takes a cycle).

## Structure
- Package load_align_pkg holds:
  - state enum {IDLE, RD0, RD1, RESP};
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DOUBLE=3.
- One sub-module, load_data_extract: a combinational shift/mask/extend taking {HI,LO}, OFF, size and unsigned, and producing DATA_SIZE bits.
- Top module holds the FSM, request capture, address generation and output registers.

## Test plan
- LB/LBU, DATA_SIZE=32, addr 0x0000_1003, word 0x80FF_1234, zero-wait:
  - LB → rsp_data 0xFFFF_FF80; LBU → 0x0000_0080;
  - one mem_req at 0x1000; rsp_valid 2 cycles after acceptance; rsp_misaligned 0.
- LH at 0x1002, word 0x8001_5678 → 0xFFFF_8001; LHU → 0x0000_8001.
- LW misaligned at 0x1001, words 0x1000=0x4433_2211 and 0x1004=0x8877_6655:
  - mem_addr 0x1000 then 0x1004 → rsp_data 0x5544_3322;
  - rsp_misaligned 1; rsp_valid 3 cycles after acceptance.
- Wrap-around: LH at 0xFFFF_FFFF → second mem_addr 0x0000_0000. Same case with 2 memory wait cycles per read: mem_addr is stable throughout and rsp_valid arrives 4 cycles later than zero-wait.
- Backpressure and illegal size:
  - rsp_ready held low 3 cycles → rsp_valid and rsp_data stable, req_ready 0;
  - req_size=3 at DATA_SIZE=32 → no mem_req, rsp_err 1, rsp_data 0.
- rst_n asserted during RD1 → all outputs 0 immediately, req_ready 1. A late mem_rvalid after release is ignored, and no rsp_valid follows.
